// File: rtl/pitch_frame_sequencer.sv
// Ping-pong frame controller: fills frame banks from the codec tick stream, hands
// completed banks to the shift datapath with a clamped shift, and tracks overruns.
`timescale 1ns/1ps
module pitch_frame_sequencer #(
    parameter int FRAME_LEN = 256,
    parameter int SHIFT_W   = 8,
    parameter int MAX_SHIFT = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [SHIFT_W-1:0]           shift_amt,
    input  logic                         sample_tick,
    output logic                         buf_wr_en,
    output logic                         buf_wr_bank,
    output logic [$clog2(FRAME_LEN)-1:0] buf_wr_addr,
    output logic                         dp_start,
    output logic                         dp_bank,
    output logic [SHIFT_W-1:0]           dp_shift,
    input  logic                         dp_done,
    output logic                         rd_bank,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic [15:0]                  frame_count,
    output logic [1:0]                   state
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic signed [SHIFT_W-1:0] MAX_POS = SHIFT_W'(MAX_SHIFT);
    localparam logic signed [SHIFT_W-1:0] MAX_NEG = SHIFT_W'(-MAX_SHIFT);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, START = 2'd2, BUSY = 2'd3} state_t;

    state_t               state_q, state_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic                 pend_q, pend_d;
    logic                 pend_bank_q, pend_bank_d;
    logic                 buf_wr_en_q, buf_wr_en_d;
    logic                 buf_wr_bank_q, buf_wr_bank_d;
    logic [AW-1:0]        buf_wr_addr_q, buf_wr_addr_d;
    logic                 dp_start_q, dp_start_d;
    logic                 dp_bank_q, dp_bank_d;
    logic [SHIFT_W-1:0]   dp_shift_q, dp_shift_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 overrun_q, overrun_d;
    logic [15:0]          frame_count_q, frame_count_d;

    logic                 tick_wr;
    logic                 frame_done;
    logic                 overrun_set;
    logic signed [SHIFT_W-1:0] shift_s;
    logic [SHIFT_W-1:0]   shift_clamped;

    assign tick_wr    = sample_tick && enable && (state_q != IDLE);
    assign frame_done = tick_wr && (wr_addr_q == AW'(FRAME_LEN - 1));
    assign shift_s    = shift_amt;

    always_comb begin
        shift_clamped = shift_amt;
        if (shift_s > MAX_POS)      shift_clamped = MAX_POS;
        else if (shift_s < MAX_NEG) shift_clamped = MAX_NEG;
    end

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        pend_d        = pend_q;
        pend_bank_d   = pend_bank_q;
        buf_wr_en_d   = 1'b0;
        buf_wr_bank_d = buf_wr_bank_q;
        buf_wr_addr_d = buf_wr_addr_q;
        dp_start_d    = 1'b0;
        dp_bank_d     = dp_bank_q;
        dp_shift_d    = dp_shift_q;
        rd_bank_d     = rd_bank_q;
        frame_count_d = frame_count_q;
        overrun_set   = 1'b0;

        if (tick_wr) begin
            buf_wr_en_d   = 1'b1;
            buf_wr_bank_d = wr_bank_q;
            buf_wr_addr_d = wr_addr_q;
            wr_addr_d     = wr_addr_q + AW'(1);
            if (frame_done) wr_bank_d = ~wr_bank_q;
        end

        case (state_q)
            IDLE: begin
                wr_bank_d = 1'b0;
                wr_addr_d = '0;
                pend_d    = 1'b0;
                if (enable) state_d = FILL;
            end
            FILL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (frame_done) begin
                    pend_bank_d = wr_bank_q;
                    state_d     = START;
                end
            end
            START: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    dp_start_d    = 1'b1;
                    dp_bank_d     = pend_bank_q;
                    dp_shift_d    = shift_clamped;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = BUSY;
                    // A frame finishing during the launch cycle waits its turn.
                    if (frame_done) begin
                        pend_d      = 1'b1;
                        pend_bank_d = wr_bank_q;
                    end
                end
            end
            BUSY: begin
                if (frame_done) begin
                    if (pend_q) overrun_set = 1'b1;
                    pend_d      = 1'b1;
                    pend_bank_d = wr_bank_q;
                end
                if (dp_done) begin
                    rd_bank_d = dp_bank_q;
                    if (!enable) begin
                        pend_d  = 1'b0;
                        state_d = IDLE;
                    end else if (pend_q || frame_done) begin
                        pend_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = overrun_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_bank_q   <= 1'b0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_bank_q <= 1'b0;
            buf_wr_addr_q <= '0;
            dp_start_q    <= 1'b0;
            dp_bank_q     <= 1'b0;
            dp_shift_q    <= '0;
            rd_bank_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            pend_q        <= pend_d;
            pend_bank_q   <= pend_bank_d;
            buf_wr_en_q   <= buf_wr_en_d;
            buf_wr_bank_q <= buf_wr_bank_d;
            buf_wr_addr_q <= buf_wr_addr_d;
            dp_start_q    <= dp_start_d;
            dp_bank_q     <= dp_bank_d;
            dp_shift_q    <= dp_shift_d;
            rd_bank_q     <= rd_bank_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign buf_wr_en   = buf_wr_en_q;
    assign buf_wr_bank = buf_wr_bank_q;
    assign buf_wr_addr = buf_wr_addr_q;
    assign dp_start    = dp_start_q;
    assign dp_bank     = dp_bank_q;
    assign dp_shift    = dp_shift_q;
    assign rd_bank     = rd_bank_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;
    assign state       = state_q;
endmodule

// File: tb/tb_pitch_frame_sequencer.sv
// Directed bench for pitch_frame_sequencer with FRAME_LEN=4; writes and frame
// launches are checked against expected queues filled as stimulus is driven.
`timescale 1ns/1ps
module tb_pitch_frame_sequencer;
    localparam int FL = 4;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  shift_amt;
    logic        sample_tick;
    logic        buf_wr_en;
    logic        buf_wr_bank;
    logic [1:0]  buf_wr_addr;
    logic        dp_start;
    logic        dp_bank;
    logic [7:0]  dp_shift;
    logic        dp_done;
    logic        rd_bank;
    logic        overrun;
    logic        overrun_clr;
    logic [15:0] frame_count;
    logic [1:0]  state;

    pitch_frame_sequencer #(.FRAME_LEN(FL), .SHIFT_W(8), .MAX_SHIFT(12)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .shift_amt(shift_amt),
        .sample_tick(sample_tick), .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank),
        .buf_wr_addr(buf_wr_addr), .dp_start(dp_start), .dp_bank(dp_bank),
        .dp_shift(dp_shift), .dp_done(dp_done), .rd_bank(rd_bank), .overrun(overrun),
        .overrun_clr(overrun_clr), .frame_count(frame_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0]  exp_wr_q[$];
    logic [24:0] exp_st_q[$];
    logic [2:0]  wr_e;
    logic [24:0] st_e;
    int   mbank;
    int   maddr;
    int   mcount;
    logic last_bank;
    int   shifts[4] = '{5, 20, -128, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clamp8(input int s);
        if (s > 12)  return 8'd12;
        if (s < -12) return 8'(-12);
        return 8'(s);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input bit expect_wr);
        sample_tick = 1'b1;
        if (expect_wr) begin
            exp_wr_q.push_back({mbank[0], maddr[1:0]});
            last_bank = mbank[0];
            maddr = maddr + 1;
            if (maddr == FL) begin
                maddr = 0;
                mbank = mbank ^ 1;
            end
        end
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic fill_frame(input int gap, input bit push_start, input int shift);
        shift_amt = 8'(shift);
        for (int i = 0; i < FL; i++) begin
            tick(1'b1);
            if (i < FL - 1) cyc(gap);
        end
        if (push_start) begin
            mcount = mcount + 1;
            exp_st_q.push_back({last_bank, clamp8(shift), 16'(mcount)});
        end
    endtask

    task automatic done_pulse();
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, 32'(buf_wr_en), 0);
        check({tag, "_wr_bank"}, 32'(buf_wr_bank), 0);
        check({tag, "_wr_addr"}, 32'(buf_wr_addr), 0);
        check({tag, "_dp_start"}, 32'(dp_start), 0);
        check({tag, "_dp_bank"}, 32'(dp_bank), 0);
        check({tag, "_dp_shift"}, 32'(dp_shift), 0);
        check({tag, "_rd_bank"}, 32'(rd_bank), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_frame_count"}, 32'(frame_count), 0);
        check({tag, "_state"}, 32'(state), 0);
    endtask

    // Output-side scoreboard: every write and every launch must match the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if (buf_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_extra", 32'(buf_wr_en), 0);
                end else begin
                    wr_e = exp_wr_q.pop_front();
                    check("wr_bank_addr", 32'({buf_wr_bank, buf_wr_addr}), 32'(wr_e));
                end
            end
            if (dp_start) begin
                if (exp_st_q.size() == 0) begin
                    check("start_extra", 32'(dp_start), 0);
                end else begin
                    st_e = exp_st_q.pop_front();
                    check("start_dp_bank", 32'(dp_bank), 32'(st_e[24]));
                    check("start_dp_shift", 32'(dp_shift), 32'(st_e[23:16]));
                    check("start_frame_count", 32'(frame_count), 32'(st_e[15:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; shift_amt = 8'd0; sample_tick = 1'b0;
        dp_done = 1'b0; overrun_clr = 1'b0;
        mbank = 0; maddr = 0; mcount = 0; last_bank = 1'b0;
        cyc(3);
        check_zero("reset");
        reset_n = 1'b1;
        cyc(2);
        tick(1'b0);
        check("idle_state", 32'(state), 0);

        enable = 1'b1;
        cyc(1);
        check("fill_state", 32'(state), 1);

        // Four frames, datapath answering promptly; rd_bank follows 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            fill_frame((i == 0) ? 9 : 2, 1'b1, shifts[i]);
            check("start_state", 32'(state), 2);
            @(negedge clk);
            check("dp_start_latency", 32'(dp_start), 1);
            check("busy_state", 32'(state), 3);
            cyc(2);
            done_pulse();
            check("rd_bank_alt", 32'(rd_bank), 32'(i % 2));
            check("back_to_fill", 32'(state), 1);
        end

        done_pulse();
        check("done_outside_busy_state", 32'(state), 1);
        check("done_outside_busy_rd", 32'(rd_bank), 1);

        // Datapath stalls across three further frames.
        fill_frame(1, 1'b1, 3);
        @(negedge clk);
        check("ovr_start", 32'(dp_start), 1);
        fill_frame(1, 1'b0, 0);
        check("ovr_after_1", 32'(overrun), 0);
        check("ovr_busy", 32'(state), 3);
        fill_frame(1, 1'b0, 0);
        check("ovr_after_2", 32'(overrun), 1);
        for (int i = 0; i < FL - 1; i++) begin
            tick(1'b1);
            cyc(1);
        end
        overrun_clr = 1'b1;
        tick(1'b1);
        overrun_clr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 1);
        shift_amt = 8'(-7);
        done_pulse();
        check("ovr_rd_bank", 32'(rd_bank), 0);
        mcount = mcount + 1;
        exp_st_q.push_back({last_bank, clamp8(-7), 16'(mcount)});
        @(negedge clk);
        check("pending_start", 32'(dp_start), 1);
        check("pending_newest_bank", 32'(dp_bank), 1);
        cyc(2);
        done_pulse();
        check("pending_done_fill", 32'(state), 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // Disable while the datapath is busy.
        fill_frame(1, 1'b1, -3);
        @(negedge clk);
        check("dis_start", 32'(dp_start), 1);
        enable = 1'b0;
        cyc(1);
        tick(1'b0);
        tick(1'b0);
        cyc(2);
        check("dis_wait_busy", 32'(state), 3);
        done_pulse();
        check("dis_rd_bank", 32'(rd_bank), 0);
        check("dis_idle", 32'(state), 0);
        mbank = 0; maddr = 0;
        enable = 1'b1;
        cyc(1);
        check("reenable_fill", 32'(state), 1);
        tick(1'b1);
        tick(1'b1);

        // Asynchronous reset with the pointer at address 2.
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        mbank = 0; maddr = 0; mcount = 0;
        cyc(2);
        check("post_reset_fill", 32'(state), 1);
        fill_frame(1, 1'b1, 30);
        @(negedge clk);
        check("post_reset_start", 32'(dp_start), 1);
        cyc(2);
        done_pulse();
        check("post_reset_rd_bank", 32'(rd_bank), 0);

        cyc(3);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 0);
        check("start_queue_drained", 32'(exp_st_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pitch_frame_sequencer.md
# pitch_frame_sequencer

Frame-level controller for the pitch-shift datapath. It sits between the audio codec's sample stream and the shift engine. It writes incoming samples into a ping-pong frame buffer and hands each completed bank to the datapath, along with a clamped copy of the software shift amount. It also tells the playback side which bank to read, and flags overruns when the datapath falls behind.

## Interface
Parameters:
- FRAME_LEN, 256, samples per frame; power of two, ≥4
- SHIFT_W, 8, width of the shift amount (two's complement semitones)
- MAX_SHIFT, 12, clamp magnitude applied to the shift amount

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run control from software
- shift_amt  in  SHIFT_W  software shift amount, signed
- sample_tick  in  1  one-cycle pulse per codec stereo sample (ADCLRCK rate)
- buf_wr_en  out  1  frame RAM write strobe
- buf_wr_bank  out  1  bank being written
- buf_wr_addr  out  log2(FRAME_LEN)  sample address within the bank
- dp_start  out  1  one-cycle start pulse to the datapath
- dp_bank  out  1  bank the datapath must process
- dp_shift  out  SHIFT_W  clamped shift, held stable from dp_start until dp_done
- dp_done  in  1  one-cycle completion pulse from the datapath
- rd_bank  out  1  processed bank for DAC playback
- overrun  out  1  sticky; set when a completed frame is discarded
- overrun_clr  in  1  clears overrun
- frame_count  out  16  frames started, wraps at 65535→0
- state  out  2  FSM state, for debug

## Operation
- The FSM has four states: IDLE=0, FILL=1, START=2, BUSY=3.
- Reset values: all outputs 0, state=IDLE, the write pointer at bank 0 / address 0, and no pending frame.
- IDLE: writes are inhibited and the write pointer is held at 0/0. When enable=1, go to FILL.
- Fill path (FILL, START, BUSY):
  - On each sample_tick, write one sample at the current bank/address, then increment the address.
  - When the address is FRAME_LEN-1, the tick completes the frame: the address wraps to 0 and the bank toggles.
- FILL: on frame completion, record the completed bank and go to START.
- START:
  - dp_start=1 for exactly one cycle.
  - dp_bank = the recorded bank.
  - dp_shift = clamp(shift_amt) sampled in this cycle.
  - frame_count increments.
  - Next state is BUSY.
- BUSY:
  - Frame completes with no frame pending: mark pending and record the bank.
  - Frame completes with a frame already pending: set overrun and replace the pending bank with the newest one. The older frame is dropped.
  - On dp_done:
    - rd_bank ← dp_bank.
    - If a frame is pending, or completes in the same cycle, clear pending and go to START.
    - Otherwise go to FILL.
- Clamp rule: signed compare. Values above +MAX_SHIFT become +MAX_SHIFT; values below −MAX_SHIFT become −MAX_SHIFT. -128 clamps to -12.
- enable=0:
  - In FILL or START: go to IDLE next cycle. A START cycle that has not yet emitted dp_start is abandoned.
  - In BUSY: wait for dp_done (rd_bank still updates), then go to IDLE and clear pending.
- dp_done outside BUSY is ignored.
- If overrun_clr and an overrun event occur in the same cycle, set wins.

## Timing
- sample_tick at cycle T → buf_wr_en=1 at T+1, carrying the address and bank that were current at T.
- Completing tick at T → START at T+1 → dp_start visible at T+2. This is after the last write (T+1) has committed.
- dp_done at T in BUSY with a frame pending → dp_start visible at T+2.
- dp_shift and dp_bank change only in START.
- rd_bank changes only in the cycle after dp_done.
- The outputs buf_wr_*, dp_*, rd_bank, overrun, frame_count and state are all registered.
- Asserting reset_n low at any point forces all outputs to their reset values immediately (asynchronous). An in-flight datapath job is forgotten.

## Test plan
- FRAME_LEN=4, enable=1, four ticks spaced 10 cycles apart → writes at addresses 0..3 in bank 0. dp_start appears 2 cycles after the 4th tick, with dp_bank=0 and frame_count=1.
- shift_amt = 5, 20, −128 on successive frames → dp_shift = 5, 12, −12.
- dp_done returned 3 cycles after each start → no overrun, and rd_bank alternates 0,1,0,1. Every frame is started.
- dp_done withheld for 3 frame periods → overrun=1 after the 2nd extra frame. The next dp_start carries the newest bank. overrun_clr returns it to 0.
- enable dropped while BUSY → no further writes. dp_done still updates rd_bank, then state=IDLE. Re-enabling restarts at bank 0, address 0.
- reset_n pulsed low mid-frame (address 2) → all outputs are 0 asynchronously. After release, the first write goes to address 0.
